// File: rtl/core_ctrl.sv
// Front-panel run controller for the TOY core: turns panel button pulses into
// fetch enable, PC load and core reset, and tracks HALT/breakpoint status and counters.
module core_ctrl #(
  parameter int unsigned RST_CYC = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  run_i,
  input  logic                  stop_i,
  input  logic                  step_i,
  input  logic                  load_pc_i,
  input  logic [7:0]            pc_sw_i,
  input  logic                  bp_en_i,
  input  logic [7:0]            bp_addr_i,
  input  logic                  clr_cnt_i,
  input  logic [7:0]            core_pc_i,
  input  logic                  core_instr_val_i,
  input  logic [15:0]           core_instr_i,
  input  logic                  core_done_i,
  output logic                  cpu_exec_o,
  output logic                  pc_wen_o,
  output logic [7:0]            pc_wdata_o,
  output logic                  core_rst_no,
  output logic [2:0]            state_o,
  output logic                  halted_o,
  output logic                  bp_hit_o,
  output logic [31:0]           retire_cnt_o,
  output logic [31:0]           cycle_cnt_o
);

  localparam int unsigned PC_W   = 8;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned RCNT_W = (RST_CYC < 2) ? 1 : $clog2(RST_CYC);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_LOADPC = 3'd5,
    ST_HALTED = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [RCNT_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic               first_q, first_d;
  logic               halted_d, bp_hit_d;
  logic [PC_W-1:0]    pc_wdata_d;
  logic               exec_d, wen_d, rstn_d;
  logic [CNT_W-1:0]   retire_d, cycle_d;
  logic               abort;
  logic               bp_trig, halt_trig;

  // Breakpoint is masked on the first RUN/STEP cycle so execution can resume from it.
  assign bp_trig   = bp_en_i && (core_pc_i == bp_addr_i) && !first_q;
  assign halt_trig = core_instr_val_i && (core_instr_i[15:12] == 4'd0);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    first_d    = 1'b0;
    halted_d   = halted_o;
    bp_hit_d   = bp_hit_o;
    pc_wdata_d = pc_wdata_o;
    abort      = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (32'(rst_cnt_q) + 32'd1 >= RST_CYC) state_d = ST_IDLE;
        else rst_cnt_d = rst_cnt_q + RCNT_W'(1);
      end
      ST_IDLE, ST_HALTED: begin
        if (!stop_i) begin
          if (load_pc_i) begin
            state_d    = ST_LOADPC;
            pc_wdata_d = pc_sw_i;
          end else if (step_i) begin
            state_d  = ST_STEP;
            first_d  = 1'b1;
            halted_d = 1'b0;
            bp_hit_d = 1'b0;
          end else if (run_i) begin
            state_d  = ST_RUN;
            first_d  = 1'b1;
            halted_d = 1'b0;
            bp_hit_d = 1'b0;
          end
        end
      end
      ST_LOADPC: begin
        state_d  = ST_IDLE;
        halted_d = 1'b0;
        bp_hit_d = 1'b0;
      end
      ST_RUN, ST_STEP: begin
        if (bp_trig)   bp_hit_d = 1'b1;
        if (halt_trig) halted_d = 1'b1;
        if (stop_i || bp_trig || halt_trig ||
            ((state_q == ST_STEP) && core_instr_val_i)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else if (core_done_i) begin
          state_d = halted_o ? ST_HALTED : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    exec_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    wen_d  = (state_d == ST_LOADPC);
    rstn_d = !((state_d == ST_RESET) || (state_d == ST_LOADPC) || abort);

    if (clr_cnt_i) begin
      retire_d = '0;
      cycle_d  = '0;
    end else begin
      retire_d = (core_instr_val_i && (retire_cnt_o != '1)) ? retire_cnt_o + CNT_W'(1) : retire_cnt_o;
      cycle_d  = (cpu_exec_o && (cycle_cnt_o != '1)) ? cycle_cnt_o + CNT_W'(1) : cycle_cnt_o;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= ST_RESET;
      rst_cnt_q    <= '0;
      first_q      <= 1'b0;
      cpu_exec_o   <= 1'b0;
      pc_wen_o     <= 1'b0;
      pc_wdata_o   <= '0;
      core_rst_no  <= 1'b0;
      halted_o     <= 1'b0;
      bp_hit_o     <= 1'b0;
      retire_cnt_o <= '0;
      cycle_cnt_o  <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      first_q      <= first_d;
      cpu_exec_o   <= exec_d;
      pc_wen_o     <= wen_d;
      pc_wdata_o   <= pc_wdata_d;
      core_rst_no  <= rstn_d;
      halted_o     <= halted_d;
      bp_hit_o     <= bp_hit_d;
      retire_cnt_o <= retire_d;
      cycle_cnt_o  <= cycle_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: directed panel scenarios plus random button/core traffic,
// every cycle compared against a behavioural model of the controller.
module tb_core_ctrl;

  localparam int unsigned RST_CYC = 2;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        run_i, stop_i, step_i, load_pc_i, bp_en_i, clr_cnt_i;
  logic [7:0]  pc_sw_i, bp_addr_i, core_pc_i;
  logic        core_instr_val_i, core_done_i;
  logic [15:0] core_instr_i;
  logic        cpu_exec_o, pc_wen_o, core_rst_no, halted_o, bp_hit_o;
  logic [7:0]  pc_wdata_o;
  logic [2:0]  state_o;
  logic [31:0] retire_cnt_o, cycle_cnt_o;

  int total = 0;
  int bad   = 0;

  core_ctrl #(.RST_CYC(RST_CYC)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .run_i(run_i), .stop_i(stop_i), .step_i(step_i),
    .load_pc_i(load_pc_i), .pc_sw_i(pc_sw_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i),
    .clr_cnt_i(clr_cnt_i), .core_pc_i(core_pc_i), .core_instr_val_i(core_instr_val_i),
    .core_instr_i(core_instr_i), .core_done_i(core_done_i), .cpu_exec_o(cpu_exec_o),
    .pc_wen_o(pc_wen_o), .pc_wdata_o(pc_wdata_o), .core_rst_no(core_rst_no),
    .state_o(state_o), .halted_o(halted_o), .bp_hit_o(bp_hit_o),
    .retire_cnt_o(retire_cnt_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: mode number, sticky flags and plain saturating counters.
  int          m_mode;
  int          m_rst_elapsed;
  bit          m_fresh;
  bit          m_exec, m_wen, m_rstn, m_halt, m_bp;
  logic [7:0]  m_wdata;
  longint      m_ret, m_cyc;
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rst_elapsed = 0; m_fresh = 0;
    m_exec = 0; m_wen = 0; m_rstn = 0; m_halt = 0; m_bp = 0;
    m_wdata = 8'h00; m_ret = 0; m_cyc = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit aborted, bp_seen, halt_seen, busy;
    nxt = m_mode; aborted = 0;
    if (clr_cnt_i) begin
      m_ret = 0; m_cyc = 0;
    end else begin
      if (core_instr_val_i) m_ret = (m_ret + 1 > CMAX) ? CMAX : m_ret + 1;
      if (m_exec)           m_cyc = (m_cyc + 1 > CMAX) ? CMAX : m_cyc + 1;
    end
    busy = (m_mode == 2) || (m_mode == 3);
    if (m_mode == 0) begin
      m_rst_elapsed++;
      if (m_rst_elapsed >= RST_CYC) nxt = 1;
    end else if (m_mode == 1 || m_mode == 6) begin
      if (stop_i) nxt = m_mode;
      else if (load_pc_i) begin nxt = 5; m_wdata = pc_sw_i; end
      else if (step_i || run_i) begin nxt = step_i ? 3 : 2; m_halt = 0; m_bp = 0; end
    end else if (m_mode == 5) begin
      nxt = 1; m_halt = 0; m_bp = 0;
    end else if (busy) begin
      bp_seen   = bp_en_i && (core_pc_i == bp_addr_i) && !m_fresh;
      halt_seen = core_instr_val_i && (core_instr_i[15:12] == 4'h0);
      if (bp_seen) m_bp = 1;
      if (halt_seen) m_halt = 1;
      if (stop_i || bp_seen || halt_seen || (m_mode == 3 && core_instr_val_i)) nxt = 4;
    end else if (m_mode == 4) begin
      if (stop_i) begin nxt = 1; aborted = 1; end
      else if (core_done_i) nxt = m_halt ? 6 : 1;
    end
    m_fresh = (nxt == 2 || nxt == 3) && !busy;
    m_mode  = nxt;
    m_exec  = (nxt == 2 || nxt == 3);
    m_wen   = (nxt == 5);
    m_rstn  = !(nxt == 0 || nxt == 5 || aborted);
  endtask

  task automatic check_all();
    check("state",  32'(state_o),      32'(m_mode));
    check("exec",   32'(cpu_exec_o),   32'(m_exec));
    check("wen",    32'(pc_wen_o),     32'(m_wen));
    check("wdata",  32'(pc_wdata_o),   32'(m_wdata));
    check("rstn",   32'(core_rst_no),  32'(m_rstn));
    check("halted", 32'(halted_o),     32'(m_halt));
    check("bphit",  32'(bp_hit_o),     32'(m_bp));
    check("retire", retire_cnt_o,      32'(m_ret));
    check("cycles", cycle_cnt_o,       32'(m_cyc));
  endtask

  task automatic cyc();
    @(posedge clk_i);
    if (!arst_ni) model_reset(); else model_step();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic idle_inputs();
    run_i = 0; stop_i = 0; step_i = 0; load_pc_i = 0; clr_cnt_i = 0;
    core_instr_val_i = 0; core_done_i = 0; core_instr_i = 16'h1000;
  endtask

  initial begin
    int exec_cnt;
    logic [31:0] ret0;
    arst_ni = 0; idle_inputs();
    pc_sw_i = 8'h00; bp_en_i = 0; bp_addr_i = 8'h14; core_pc_i = 8'h00;
    model_reset();

    // Reset and release
    cyc(); cyc();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_rstn", 32'(core_rst_no), 32'd0);
    arst_ni = 1;
    cyc();
    check("rel_hold", 32'(core_rst_no), 32'd0);
    cyc();
    check("rel_rstn", 32'(core_rst_no), 32'd1);
    check("rel_state", 32'(state_o), 32'd1);
    check("rel_exec", 32'(cpu_exec_o), 32'd0);

    // Load PC
    pc_sw_i = 8'h10; load_pc_i = 1; cyc(); load_pc_i = 0;
    check("ld_wen", 32'(pc_wen_o), 32'd1);
    check("ld_wdata", 32'(pc_wdata_o), 32'h10);
    check("ld_rstn", 32'(core_rst_no), 32'd0);
    cyc();
    check("ld_wen_off", 32'(pc_wen_o), 32'd0);
    check("ld_idle", 32'(state_o), 32'd1);

    // Run to HALT after five retirements
    run_i = 1; cyc(); run_i = 0;
    check("run_exec", 32'(cpu_exec_o), 32'd1);
    core_instr_val_i = 1; core_instr_i = 16'h1234;
    repeat (5) cyc();
    core_instr_i = 16'h0000; cyc();
    check("halt_exec", 32'(cpu_exec_o), 32'd0);
    check("halt_drain", 32'(state_o), 32'd4);
    core_instr_val_i = 0; core_instr_i = 16'h1000; core_done_i = 1; cyc(); core_done_i = 0;
    check("halt_state", 32'(state_o), 32'd6);
    check("halt_flag", 32'(halted_o), 32'd1);
    check("halt_ret", retire_cnt_o, 32'd6);

    // Breakpoint and resume from it
    bp_en_i = 1; bp_addr_i = 8'h14; core_pc_i = 8'h10;
    run_i = 1; cyc(); run_i = 0;
    check("bp_clr_halt", 32'(halted_o), 32'd0);
    for (int p = 8'h11; p <= 8'h14; p++) begin
      core_pc_i = 8'(p); cyc();
    end
    check("bp_hit", 32'(bp_hit_o), 32'd1);
    check("bp_drain", 32'(state_o), 32'd4);
    core_done_i = 1; cyc(); core_done_i = 0;
    check("bp_idle", 32'(state_o), 32'd1);
    run_i = 1; cyc(); run_i = 0;
    cyc();
    check("bp_resume", 32'(cpu_exec_o), 32'd1);
    bp_en_i = 0; core_pc_i = 8'h20; stop_i = 1; cyc(); stop_i = 0;
    core_done_i = 1; cyc(); core_done_i = 0;

    // Step with the retirement arriving on the fourth exec cycle
    ret0 = retire_cnt_o; exec_cnt = 0;
    step_i = 1; cyc(); step_i = 0; exec_cnt += int'(cpu_exec_o);
    repeat (3) begin cyc(); exec_cnt += int'(cpu_exec_o); end
    core_instr_val_i = 1; cyc(); core_instr_val_i = 0; exec_cnt += int'(cpu_exec_o);
    check("step_exec_cnt", 32'(exec_cnt), 32'd4);
    check("step_drain", 32'(state_o), 32'd4);
    core_done_i = 1; cyc(); core_done_i = 0;
    check("step_idle", 32'(state_o), 32'd1);
    check("step_ret", retire_cnt_o - ret0, 32'd1);

    // Abort a stuck drain
    run_i = 1; cyc(); run_i = 0;
    stop_i = 1; cyc(); stop_i = 0;
    cyc(); cyc();
    check("abort_wait", 32'(state_o), 32'd4);
    stop_i = 1; cyc(); stop_i = 0;
    check("abort_rst", 32'(core_rst_no), 32'd0);
    cyc();
    check("abort_rel", 32'(core_rst_no), 32'd1);
    check("abort_idle", 32'(state_o), 32'd1);

    // Load beats run on the same cycle
    run_i = 1; load_pc_i = 1; pc_sw_i = 8'h33; cyc(); run_i = 0; load_pc_i = 0;
    check("prio_state", 32'(state_o), 32'd5);
    check("prio_exec", 32'(cpu_exec_o), 32'd0);
    check("prio_wdata", 32'(pc_wdata_o), 32'h33);
    cyc();

    // Clear wins over a retirement
    core_instr_val_i = 1; clr_cnt_i = 1; cyc(); core_instr_val_i = 0; clr_cnt_i = 0;
    check("clr_ret", retire_cnt_o, 32'd0);

    // Asynchronous reset in the middle of a run
    run_i = 1; cyc(); run_i = 0; cyc();
    #2 arst_ni = 0;
    #1;
    check("arst_exec", 32'(cpu_exec_o), 32'd0);
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_rstn", 32'(core_rst_no), 32'd0);
    check("arst_cyc", cycle_cnt_o, 32'd0);
    model_reset();
    cyc();
    arst_ni = 1;
    repeat (3) cyc();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      run_i            = ($urandom_range(0, 9) == 0);
      stop_i           = ($urandom_range(0, 24) == 0);
      step_i           = ($urandom_range(0, 14) == 0);
      load_pc_i        = ($urandom_range(0, 19) == 0);
      clr_cnt_i        = ($urandom_range(0, 99) == 0);
      pc_sw_i          = 8'($urandom);
      bp_en_i          = ((i / 256) % 2) == 1;
      core_pc_i        = ($urandom_range(0, 7) == 0) ? 8'h14 : 8'($urandom);
      core_instr_val_i = ($urandom_range(0, 2) == 0);
      core_instr_i     = ($urandom_range(0, 11) == 0) ? 16'h0ABC : (16'($urandom) | 16'h1000);
      core_done_i      = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
